pc_sequencer: RTL

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 133 +++++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// Program-counter sequencer with a LIFO return stack for call/ret.
// Commands use a fixed priority; halt freezes all state until reset.
module pc_sequencer #(
    parameter int unsigned     AW         = 6,
    parameter int unsigned     DEPTH      = 4,
    parameter logic [AW-1:0]   RESET_ADDR = '0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         stall,
    input  logic                         halt,
    input  logic                         jump,
    input  logic                         branch,
    input  logic                         cond,
    input  logic [AW-1:0]                offset,
    input  logic [AW-1:0]                target,
    input  logic                         call,
    input  logic                         ret,
    output logic [AW-1:0]                pc,
    output logic [$clog2(DEPTH+1)-1:0]   depth,
    output logic                         stack_full,
    output logic                         stack_empty,
    output logic                         stack_err,
    output logic                         halted
);

    localparam int unsigned     DW        = $clog2(DEPTH + 1);
    localparam int unsigned     IW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned     SLOTS     = 1 << IW;
    localparam logic [DW-1:0]   DEPTH_MAX = DW'(DEPTH);

    typedef enum logic {
        ST_RUN,
        ST_HALT
    } state_t;

    state_t            state;
    state_t            state_next;
    logic              advance;

    logic [AW-1:0]     stack_mem [SLOTS];
    logic [AW-1:0]     pc_next;
    logic [AW-1:0]     pc_inc;
    logic [DW-1:0]     depth_next;
    logic              err_next;
    logic              push_en;
    logic [IW-1:0]     push_idx;
    logic [IW-1:0]     top_idx;

    assign pc_inc      = pc + AW'(1);
    assign stack_full  = (depth == DEPTH_MAX);
    assign stack_empty = (depth == '0);
    // Slot array is rounded up to a power of two so the index width is exact.
    assign push_idx    = depth[IW-1:0];
    assign top_idx     = IW'(depth - DW'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_RUN:  if (halt) state_next = ST_HALT;
            ST_HALT: state_next = ST_HALT;
            default: state_next = ST_RUN;
        endcase
    end

    always_comb begin
        halted  = (state == ST_HALT);
        advance = (state == ST_RUN) && !halt && !stall;
    end

    always_comb begin
        pc_next    = pc;
        depth_next = depth;
        err_next   = stack_err;
        push_en    = 1'b0;
        if (advance) begin
            if (ret) begin
                if (stack_empty) begin
                    err_next = 1'b1;
                end else begin
                    pc_next    = stack_mem[top_idx];
                    depth_next = depth - DW'(1);
                end
            end else if (call) begin
                if (stack_full) begin
                    err_next = 1'b1;
                end else begin
                    push_en    = 1'b1;
                    pc_next    = target;
                    depth_next = depth + DW'(1);
                end
            end else if (jump) begin
                pc_next = target;
            end else if (branch && cond) begin
                // Modular add: sign extension of offset is implicit at width AW.
                pc_next = pc + offset;
            end else begin
                pc_next = pc_inc;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc        <= RESET_ADDR;
            depth     <= '0;
            stack_err <= 1'b0;
        end else begin
            pc        <= pc_next;
            depth     <= depth_next;
            stack_err <= err_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < SLOTS; i++) begin
                stack_mem[i] <= '0;
            end
        end else if (push_en) begin
            stack_mem[push_idx] <= pc_inc;
        end
    end

endmodule
